mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous instruction/data memory between the fetch stage (instruction reads) and the load/store unit (data reads and writes).
- Grants at most one access per cycle. Load/store has priority, but a starvation limit guarantees fetch progress.
- Returns read data to the correct requester one cycle after issue and raises per-requester stall signals.
- Supports a branch flush that cancels fetches.

Parameters:
- XLEN, 32, data width of memory words and requester data buses
- ALEN, 32, byte-address width
- STARVE_MAX, 4, max consecutive load/store grants while fetch waits; range 1..15

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch requests a read at if_addr
- if_addr  in  ALEN  fetch byte address
- if_flush  in  1  branch taken: cancel fetch issue this cycle
- if_stall  out  1  fetch request not granted this cycle; hold if_addr
- if_valid  out  1  if_rdata holds the response to last cycle's fetch grant
- if_rdata  out  XLEN  instruction word
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ALEN  data byte address
- ls_wdata  in  XLEN  store data
- ls_stall  out  1  load/store request not granted this cycle
- ls_valid  out  1  response to last cycle's load/store grant
- ls_rdata  out  XLEN  load data; 0 for stores
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write this cycle
- mem_addr  out  ALEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Grant decision is combinational each cycle:
  - grant_if = if_req & ~if_flush & (~ls_req | starve_cnt == STARVE_MAX)
  - grant_ls = ls_req & ~grant_if
- Memory port drive:
  - mem_en = grant_if | grant_ls.
  - mem_addr/mem_wdata/mem_we come from the granted requester.
  - When idle: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Stalls:
  - if_stall = if_req & ~grant_if. This includes the flush cycle; the fetch re-presents its new PC next cycle.
  - ls_stall = ls_req & ~grant_ls.
- Requester rule: a requester holds req, addr and wdata stable while its stall is high. The arbiter does not latch request data.
- Pipelined response, 1-cycle latency; back-to-back issue allowed every cycle.
  - resp_owner register: NONE, IF or LS. Loaded on every posedge with the owner granted that cycle.
  - if_valid = (resp_owner == IF); if_rdata = mem_rdata when valid, else 0.
  - ls_valid = (resp_owner == LS); ls_rdata = mem_rdata for loads, else 0.
  - resp_we register records a store, so ls_rdata = 0 for store responses.
- Starvation counter, width 4:
  - Increments on a grant_ls cycle when if_req is high and not flushed, saturating at STARVE_MAX.
  - Clears on grant_if, or when if_req is low.
- Flush:
  - if_flush in cycle N blocks any fetch grant in N, so no if_valid appears in N+1.
  - A response already issued in N-1 still appears as if_valid in N; the fetch stage discards it.
- Simultaneous if_req & ls_req with starve_cnt < STARVE_MAX: LS is granted, IF is stalled, and the counter increments.
- Reset:
  - resp_owner = NONE, resp_we = 0, starve_cnt = 0.
  - All outputs 0 while reset is high (stalls included).
  - Reset mid-operation drops any pending response: no valid pulse in the cycle after reset deasserts.

Decomposition:
- Shared package `mem_arb_pkg`:
  - enum owner_t {OWN_NONE, OWN_IF, OWN_LS}
  - localparam STARVE_W = 4
- One natural sub-module: `starve_counter` (saturating counter with clear/inc/limit compare).
- Response register and grant logic stay in the top.

Test Plan:
- Reset, then if_req=1, if_addr=0x0 with mem[0]=0x00500093 → mem_en=1, mem_addr=0 in cycle 0; if_valid=1, if_rdata=0x00500093 in cycle 1; if_stall=0 throughout.
- if_req (addr 0x4) and ls_req load (addr 0x40, mem=0x12345678) in the same cycle → cycle 0: ls granted, if_stall=1; cycle 1: ls_valid=1, ls_rdata=0x12345678, fetch granted; cycle 2: if_valid=1.
- ls_req held high for 10 cycles, if_req high, STARVE_MAX=4 → LS granted cycles 0-3; IF granted cycle 4 with ls_stall=1; LS granted cycles 5-8; IF granted again cycle 9.
- Store: ls_we=1, addr 0x80, wdata 0xDEADBEEF → cycle 0: mem_we=1; cycle 1: ls_valid=1, ls_rdata=0; subsequent load of 0x80 → ls_rdata=0xDEADBEEF.
- Branch: fetch 0x8 granted cycle 0; cycle 1: if_flush=1, if_req=1 at 0x8 → cycle 1: if_valid=1 (old response), if_stall=1, mem_en=0; cycle 2: if_valid=0; new PC 0x100 requested in cycle 2 returns in cycle 3.
- Reset asserted in the cycle after a load grant → no ls_valid after reset; all outputs 0 during reset; starve_cnt restarts at 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   owner_t  : which requester a pending memory response belongs to
//   STARVE_W : width of the fetch starvation counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of load/store grants made while fetch waits.
//   clk, reset : clock and synchronous active-high reset
//   clr        : restart the count (fetch served or no longer waiting)
//   inc        : one more load/store grant taken while fetch waits
//   at_limit   : count has reached MAX, so fetch must win the next conflict
module starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(MAX);

    logic [STARVE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (inc && cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

    assign at_limit = cnt == LIMIT;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory between fetch and load/store.
//   clk, reset                     : clock and synchronous active-high reset
//   if_req/if_addr/if_flush        : fetch read request, cancelled by a branch flush
//   if_stall/if_valid/if_rdata     : fetch not granted / response from last cycle's grant
//   ls_req/ls_we/ls_addr/ls_wdata  : load/store request
//   ls_stall/ls_valid/ls_rdata     : load/store not granted / response (0 for stores)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port, read data one cycle after issue
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [ALEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [ALEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_stall,
    output logic            ls_valid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    logic   grant_if;
    logic   grant_ls;
    logic   at_limit;
    owner_t resp_owner;
    logic   resp_we;

    // Load/store wins conflicts until it has starved fetch STARVE_MAX times in a row.
    // Grants are forced low during reset so every output reads 0.
    assign grant_if = ~reset & if_req & ~if_flush & (~ls_req | at_limit);
    assign grant_ls = ~reset & ls_req & ~grant_if;

    starve_counter #(.MAX(STARVE_MAX)) u_starve (
        .clk      (clk),
        .reset    (reset),
        .clr      (grant_if | ~if_req),
        .inc      (grant_ls & if_req & ~if_flush),
        .at_limit (at_limit)
    );

    always_comb begin
        mem_en    = grant_if | grant_ls;
        mem_we    = grant_ls & ls_we;
        mem_addr  = grant_if ? if_addr : (grant_ls ? ls_addr : '0);
        mem_wdata = grant_ls ? ls_wdata : '0;
        if_stall  = ~reset & if_req & ~grant_if;
        ls_stall  = ~reset & ls_req & ~grant_ls;
        if_valid  = ~reset & (resp_owner == OWN_IF);
        ls_valid  = ~reset & (resp_owner == OWN_LS);
        if_rdata  = if_valid ? mem_rdata : '0;
        ls_rdata  = (ls_valid & ~resp_we) ? mem_rdata : '0;
    end

    // Response owner tracks the single in-flight access; reset drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_owner <= OWN_NONE;
            resp_we    <= 1'b0;
        end else begin
            resp_owner <= grant_if ? OWN_IF : (grant_ls ? OWN_LS : OWN_NONE);
            resp_we    <= grant_ls & ls_we;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a reference model.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int ALEN = 32;
    localparam int SMAX = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            if_req = 1'b0;
    logic [ALEN-1:0] if_addr = '0;
    logic            if_flush = 1'b0;
    logic            if_stall;
    logic            if_valid;
    logic [XLEN-1:0] if_rdata;
    logic            ls_req = 1'b0;
    logic            ls_we = 1'b0;
    logic [ALEN-1:0] ls_addr = '0;
    logic [XLEN-1:0] ls_wdata = '0;
    logic            ls_stall;
    logic            ls_valid;
    logic [XLEN-1:0] ls_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [ALEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata = '0;

    logic [XLEN-1:0] mem [256];
    logic [XLEN-1:0] ref_mem [256];

    int n_checks = 0;
    int n_fail = 0;

    int              m_owner = 0;
    int              m_starve = 0;
    logic            m_we = 1'b0;
    logic [XLEN-1:0] m_data = '0;

    logic            c_if_stall, c_ls_stall, c_if_valid, c_ls_valid, c_mem_en, c_mem_we;
    logic [XLEN-1:0] c_if_rdata, c_ls_rdata;
    logic [ALEN-1:0] c_mem_addr;

    mem_port_arbiter #(.XLEN(XLEN), .ALEN(ALEN), .STARVE_MAX(SMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_stall  (if_stall),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_stall  (ls_stall),
        .ls_valid  (ls_valid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                mem[mem_addr[9:2]] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are set just after a rising edge; outputs are compared mid-cycle,
    // then the model advances on the edge.
    task automatic cycle();
        logic gif, gls;
        int   nxt;
        #3;
        gif = !reset && if_req && !if_flush && (!ls_req || m_starve >= SMAX);
        gls = !reset && ls_req && !gif;
        check("mem_en",    XLEN'(mem_en),   XLEN'(gif || gls));
        check("mem_we",    XLEN'(mem_we),   XLEN'(gls && ls_we));
        check("mem_addr",  mem_addr,        gif ? if_addr : (gls ? ls_addr : '0));
        check("mem_wdata", mem_wdata,       gls ? ls_wdata : '0);
        check("if_stall",  XLEN'(if_stall), XLEN'(!reset && if_req && !gif));
        check("ls_stall",  XLEN'(ls_stall), XLEN'(!reset && ls_req && !gls));
        check("if_valid",  XLEN'(if_valid), XLEN'(!reset && m_owner == 1));
        check("ls_valid",  XLEN'(ls_valid), XLEN'(!reset && m_owner == 2));
        check("if_rdata",  if_rdata, (!reset && m_owner == 1) ? m_data : '0);
        check("ls_rdata",  ls_rdata, (!reset && m_owner == 2 && !m_we) ? m_data : '0);
        c_if_stall = if_stall;
        c_ls_stall = ls_stall;
        c_if_valid = if_valid;
        c_ls_valid = ls_valid;
        c_if_rdata = if_rdata;
        c_ls_rdata = ls_rdata;
        c_mem_en   = mem_en;
        c_mem_we   = mem_we;
        c_mem_addr = mem_addr;
        @(posedge clk);
        if (reset) begin
            m_owner  = 0;
            m_we     = 1'b0;
            m_starve = 0;
        end else begin
            m_owner = gif ? 1 : (gls ? 2 : 0);
            m_we    = gls && ls_we;
            m_data  = gif ? ref_mem[if_addr[9:2]] : (gls ? ref_mem[ls_addr[9:2]] : '0);
            if (gls && ls_we)
                ref_mem[ls_addr[9:2]] = ls_wdata;
            nxt = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
            if (gif || !if_req)
                m_starve = 0;
            else if (gls && !if_flush)
                m_starve = nxt;
        end
        #1;
    endtask

    initial begin
        logic [XLEN-1:0] v;
        logic [9:0]      mask;
        logic            was_flush;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[0]  = 32'h0050_0093; ref_mem[0]  = 32'h0050_0093;
        mem[16] = 32'h1234_5678; ref_mem[16] = 32'h1234_5678;
        mem[64] = 32'hCAFE_F00D; ref_mem[64] = 32'hCAFE_F00D;
        @(posedge clk); #1;

        // reset with requests pending: everything must read 0
        if_req = 1'b1; ls_req = 1'b1;
        cycle();
        check("rst_if_stall", XLEN'(c_if_stall), '0);
        check("rst_mem_en",   XLEN'(c_mem_en),   '0);
        reset = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        cycle();

        // single fetch
        if_req = 1'b1; if_addr = 32'h0;
        cycle();
        check("f_en",    XLEN'(c_mem_en),   32'd1);
        check("f_stall", XLEN'(c_if_stall), '0);
        if_req = 1'b0;
        cycle();
        check("f_valid", XLEN'(c_if_valid), 32'd1);
        check("f_rdata", c_if_rdata, 32'h0050_0093);

        // simultaneous fetch and load
        if_req = 1'b1; if_addr = 32'h4;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
        cycle();
        check("c_if_stall", XLEN'(c_if_stall), 32'd1);
        check("c_addr",     c_mem_addr, 32'h40);
        ls_req = 1'b0;
        cycle();
        check("c_ls_valid", XLEN'(c_ls_valid), 32'd1);
        check("c_ls_rdata", c_ls_rdata, 32'h1234_5678);
        check("c_if_grant", XLEN'(c_if_stall), '0);
        if_req = 1'b0;
        cycle();
        check("c_if_valid", XLEN'(c_if_valid), 32'd1);

        // starvation limit
        mask = '0;
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if_addr = {22'b0, 8'($urandom_range(255)), 2'b0};
            ls_addr = {22'b0, 8'($urandom_range(255)), 2'b0};
            cycle();
            if (!c_if_stall)
                mask[i] = 1'b1;
        end
        check("starve_mask", XLEN'(mask), 32'h210);
        if_req = 1'b0; ls_req = 1'b0;
        cycle();

        // store then load back
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h80; ls_wdata = 32'hDEAD_BEEF;
        cycle();
        check("st_we", XLEN'(c_mem_we), 32'd1);
        ls_we = 1'b0; ls_wdata = '0;
        cycle();
        check("st_valid", XLEN'(c_ls_valid), 32'd1);
        check("st_rdata", c_ls_rdata, '0);
        ls_req = 1'b0;
        cycle();
        check("ld_rdata", c_ls_rdata, 32'hDEAD_BEEF);

        // branch flush
        if_req = 1'b1; if_addr = 32'h8;
        cycle();
        if_flush = 1'b1;
        cycle();
        check("fl_valid", XLEN'(c_if_valid), 32'd1);
        check("fl_stall", XLEN'(c_if_stall), 32'd1);
        check("fl_en",    XLEN'(c_mem_en),   '0);
        if_flush = 1'b0; if_addr = 32'h100;
        cycle();
        check("fl_after", XLEN'(c_if_valid), '0);
        if_req = 1'b0;
        cycle();
        check("fl_new", c_if_rdata, 32'hCAFE_F00D);

        // reset right after a load grant
        ls_req = 1'b1; ls_addr = 32'h40;
        cycle();
        ls_req = 1'b0; reset = 1'b1;
        cycle();
        check("rr_valid", XLEN'(c_ls_valid), '0);
        reset = 1'b0;
        cycle();
        check("rr_after", XLEN'(c_ls_valid), '0);
        mask = '0;
        if_req = 1'b1; ls_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (!c_if_stall)
                mask[i] = 1'b1;
        end
        check("rr_starve", XLEN'(mask), 32'h10);
        if_req = 1'b0; ls_req = 1'b0;
        cycle();

        // randomized traffic obeying the hold-while-stalled rule
        was_flush = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(99) == 0);
            if (!c_if_stall || was_flush) begin
                if_req  = ($urandom_range(9) < 7);
                if_addr = {22'b0, 8'($urandom_range(255)), 2'b0};
            end
            if (!c_ls_stall) begin
                ls_req   = ($urandom_range(9) < 6);
                ls_we    = ($urandom_range(2) == 0);
                ls_addr  = {22'b0, 8'($urandom_range(255)), 2'b0};
                ls_wdata = $urandom;
            end
            if_flush  = ($urandom_range(9) == 0);
            was_flush = if_flush;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
